// File: rtl/mod241_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod241_pkg
// Purpose  : Shared constants, state encoding and weight lookup for the
//            streaming X mod 241 residue engine.
// Revision : 1.0 - initial release
// ============================================================================
package mod241_pkg;

  localparam int N_BITS  = 300;
  localparam int DIGIT_W = 8;
  localparam int ND      = (N_BITS + DIGIT_W - 1) / DIGIT_W;   // 38 digits
  localparam int IDX_W   = $clog2(ND + 1);

  localparam logic [7:0] MOD = 8'd241;

  // Bits of the top digit that belong to the operand (300 - 37*8 = 4).
  localparam int         TOP_BITS = N_BITS - (ND - 1) * DIGIT_W;
  localparam logic [7:0] TOP_MASK = 8'((1 << TOP_BITS) - 1);

  // 256^i mod 241 repeats with period 3: 1, 15, 225.
  localparam logic [2:0][7:0] WEIGHT = {8'd225, 8'd15, 8'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Weight for the current digit position; wsel never reaches 3.
  function automatic logic [7:0] weight_of(input logic [1:0] wsel);
    logic [7:0] w;
    case (wsel)
      2'd1:    w = WEIGHT[1];
      2'd2:    w = WEIGHT[2];
      default: w = WEIGHT[0];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod241_fold16.sv
`default_nettype none
// ============================================================================
// Module   : mod241_fold16
// Purpose  : Combinational 16-bit value -> residue mod 241 (0..240).
//            Uses 256 == 15 (mod 241): two folds shrink the value to <=480,
//            then two conditional subtracts finish the reduction.
// Revision : 1.0 - initial release
// ============================================================================
module mod241_fold16
  import mod241_pkg::*;
(
  input  logic [15:0] in_val,
  output logic [7:0]  out_res
);

  logic [11:0] fold1;
  logic [8:0]  fold2;
  logic [8:0]  sub1;
  logic [8:0]  sub2;

  // Fold high byte onto low byte twice, then bring the <=480 result below 241.
  always_comb begin
    fold1   = 12'(in_val[7:0]) + 12'(in_val[15:8]) * 12'd15;   // <= 4080
    fold2   = 9'(fold1[7:0]) + 9'(fold1[11:8]) * 9'd15;        // <= 480
    sub1    = (fold2 >= 9'(MOD)) ? (fold2 - 9'(MOD)) : fold2;
    sub2    = (sub1 >= 9'(MOD)) ? (sub1 - 9'(MOD)) : sub1;
    out_res = 8'(sub2);
  end

endmodule
`default_nettype wire

// File: rtl/x_300_mod_241_serial.sv
`default_nettype none
// ============================================================================
// Module   : x_300_mod_241_serial
// Purpose  : Streaming residue engine. Accepts a 300-bit operand as an
//            LSB-first byte stream (valid/ready) and returns X mod 241.
//            Optional build macro X_MOD_241_CHECK_EN adds an expected-residue
//            input and a registered mismatch flag.
// Revision : 1.0 - initial release
// ============================================================================
module x_300_mod_241_serial
  import mod241_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic       out_err
`ifdef X_MOD_241_CHECK_EN
  ,
  input  logic [7:0] exp_res,
  output logic       out_mismatch
`endif
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [1:0]       wsel_q, wsel_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_res_q, out_res_d;
  logic             out_err_q, out_err_d;

  logic             beat;
  logic             at_top;
  logic             frame_end;
  logic             frame_err;
  logic [7:0]       digit;
  logic [15:0]      prod;
  logic [7:0]       prod_res;
  logic [8:0]       acc_sum;
  logic [7:0]       acc_n;

`ifdef X_MOD_241_CHECK_EN
  logic             mismatch_q, mismatch_d;
`endif

  // Input is accepted whenever no residue is pending and reset is released.
  assign in_ready  = ~rst & (state_q != DONE);
  assign beat      = in_valid & in_ready;
  assign at_top    = (idx_q == IDX_W'(ND - 1));
  assign frame_end = beat & (at_top | in_last);
  // An error is a frame ended by only one of the two criteria.
  assign frame_err = at_top ^ in_last;

  // Digit weighting: mask unused top-digit bits, multiply by 256^i mod 241.
  always_comb begin
    digit = at_top ? (in_data & TOP_MASK) : in_data;
    prod  = 16'(digit) * 16'(weight_of(wsel_q));
  end

  mod241_fold16 u_fold (
    .in_val  (prod),
    .out_res (prod_res)
  );

  // Modular accumulate: both terms are below 241, so one subtract suffices.
  always_comb begin
    acc_sum = 9'(acc_q) + 9'(prod_res);
    acc_n   = (acc_sum >= 9'(MOD)) ? 8'(acc_sum - 9'(MOD)) : 8'(acc_sum);
  end

  // Next-state, datapath update and output-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    wsel_d      = wsel_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_err_d   = out_err_q;
`ifdef X_MOD_241_CHECK_EN
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          acc_d   = acc_n;
          idx_d   = idx_q + IDX_W'(1);
          wsel_d  = (wsel_q == 2'd2) ? 2'd0 : (wsel_q + 2'd1);
          state_d = ACC;
          if (frame_end) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_res_d   = acc_n;
            out_err_d   = frame_err;
`ifdef X_MOD_241_CHECK_EN
            mismatch_d  = (acc_n != exp_res);
`endif
          end
        end
      end
      DONE: begin
        // Residue held until the consumer takes it; then start clean.
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = 8'd0;
          idx_d       = '0;
          wsel_d      = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= 8'd0;
      wsel_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_res_q   <= 8'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      wsel_q      <= wsel_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef X_MOD_241_CHECK_EN
  // Mismatch flag register, updated alongside the residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign out_mismatch = mismatch_q;
`endif

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire
